muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy duration of mult/multu, in cycles.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy duration of div/divu, in cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: an md_op is issued from the E stage this cycle.
REQ-006 SHALL have port md_op, input, 3 bits: operation code (see REQ-010).
REQ-007 SHALL have ports A and B, input, 32 bits each: operands (rs, rt), sampled when start=1.
REQ-008 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO, driven directly from registers; mfhi/mflo read these.

Function
REQ-010 md_op codes SHALL be: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; code 7 SHALL act as none.
REQ-011 The FSM SHALL have exactly two states, IDLE and RUN, plus a 4-bit down-counter cnt.
REQ-012 In IDLE with start=1 and md_op in 1..4, the unit SHALL latch the result into pending registers and load cnt (MULT_CYCLES or DIV_CYCLES), then go to RUN.
- busy=1 from the next cycle.
REQ-013 In RUN, cnt SHALL decrement each cycle.
- On the edge where cnt reaches 1 -> 0: pending results SHALL commit to hi/lo, busy SHALL drop, and the FSM SHALL return to IDLE.
- Total: busy high for exactly N cycles; hi/lo visible N cycles after the start edge.
REQ-014 mult SHALL be signed and multu unsigned 32x32->64 multiplication: {hi,lo} = product.
REQ-015 div/divu SHALL write lo = quotient (truncated toward zero) and hi = remainder (sign of the dividend); div is signed, divu unsigned.
REQ-016 div 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0x00000000.
REQ-017 Divide by zero (B=0) SHALL still occupy DIV_CYCLES with busy=1, and SHALL leave hi/lo unchanged at commit.
REQ-018 mthi/mtlo in IDLE SHALL write A to hi/lo at the same edge, with busy remaining 0.
REQ-019 start while busy=1 SHALL be ignored, whatever md_op is; hi/lo and the in-flight op SHALL be unaffected (the hazard unit stalls such instructions).
REQ-020 start=1 with md_op none SHALL have no effect.
REQ-021 A new start SHALL be accepted in the cycle after busy drops; no bubble beyond that is required.

Reset
REQ-022 reset=1 at a clock edge SHALL force IDLE, cnt=0, busy=0, hi=0, lo=0 and clear the pending registers.
REQ-023 A reset asserted mid-operation SHALL abort the operation; no partial or pending result SHALL ever reach hi/lo.
REQ-024 reset SHALL take priority over start at the same edge.

Structure
REQ-025 The md_op codes SHALL be `define macros in the shared head.v, alongside the ALU op codes.
REQ-026 The MULT_CYCLES and DIV_CYCLES defaults SHALL be defined in head.v as `define macros.
REQ-027 Product and quotient/remainder SHALL be computed combinationally in one sub-module, mdu_calc, with inputs A, B, md_op and outputs res_hi, res_lo, div_zero.
- muldiv_unit SHALL hold the FSM, counter, pending registers and HI/LO.

Verification
REQ-028 Scenario mult: A=0xFFFFFFFE, B=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-029 Scenario multu: A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles, hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 Scenario div: A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 Scenario divide by zero: with hi=0x11, lo=0x22, divu A=5, B=0 -> busy for 10 cycles; hi/lo unchanged.
REQ-032 Scenario collision: start mult, then issue mthi A=0x55 during cycle 2 of busy -> ignored; final hi/lo are the mult result.
REQ-033 Scenario reset: start div, assert reset in cycle 4 -> busy=0 and hi=lo=0 the next cycle; no commit ever occurs.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared op-code macros (ALU and md_op), cycle defaults, FSM constants
`ifndef MULDIV_HEAD_SV
`define MULDIV_HEAD_SV

`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_AND 4'd2
`define ALU_OR  4'd3
`define ALU_XOR 4'd4
`define ALU_SLT 4'd5

`define MD_NONE  3'd0
`define MD_MULT  3'd1
`define MD_MULTU 3'd2
`define MD_DIV   3'd3
`define MD_DIVU  3'd4
`define MD_MTHI  3'd5
`define MD_MTLO  3'd6

`define MULT_CYCLES_DEF 5
`define DIV_CYCLES_DEF  10

`endif

package muldiv_unit_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == `MD_MULT) || (op == `MD_MULTU) || (op == `MD_DIV) || (op == `MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational 32x32 multiply and divide/remainder for the mul/div unit
module mdu_calc
  import muldiv_unit_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  md_op,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        dvs;
  logic signed [31:0] q_raw;
  logic signed [31:0] r_raw;
  logic [31:0]        q_u;
  logic [31:0]        r_u;
  logic               ovf;

  // Divisor forced to 1 on zero so the dividers never see x; the result is discarded anyway.
  assign dvs    = (B == 32'd0) ? 32'd1 : B;
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign q_raw  = $signed(A) / $signed(dvs);
  assign r_raw  = $signed(A) % $signed(dvs);
  assign q_u    = A / dvs;
  assign r_u    = A % dvs;
  assign ovf    = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  always_comb begin
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    div_zero = 1'b0;
    case (md_op)
      `MD_MULT:  {res_hi, res_lo} = prod_s;
      `MD_MULTU: {res_hi, res_lo} = prod_u;
      `MD_DIV: begin
        div_zero = (B == 32'd0);
        res_lo   = ovf ? 32'h8000_0000 : q_raw;
        res_hi   = ovf ? 32'd0 : r_raw;
      end
      `MD_DIVU: begin
        div_zero = (B == 32'd0);
        res_lo   = q_u;
        res_hi   = r_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle mult/div unit: IDLE/RUN FSM, countdown, pending results, HI/LO
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MULT_CYCLES = `MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = `DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_zero;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_zero;

  mdu_calc u_calc (
    .A       (A),
    .B       (B),
    .md_op   (md_op),
    .res_hi  (res_hi),
    .res_lo  (res_lo),
    .div_zero(div_zero)
  );

  assign busy = (state == RUN);

  // Results are captured at issue; the countdown only models latency before they become visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_zero <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else if (state == IDLE) begin
      if (start) begin
        if (is_long_op(md_op)) begin
          pend_hi   <= res_hi;
          pend_lo   <= res_lo;
          pend_zero <= div_zero;
          cnt       <= ((md_op == `MD_MULT) || (md_op == `MD_MULTU)) ? MULT_CNT : DIV_CNT;
          state     <= RUN;
        end else if (md_op == `MD_MTHI) begin
          hi <= A;
        end else if (md_op == `MD_MTLO) begin
          lo <= A;
        end
      end
    end else begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        if (!pend_zero) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  vec_t        vecs[14];

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .md_op(md_op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain architectural arithmetic on 64-bit integers.
  task automatic model_step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int cyc);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    cyc = 0;
    case (op)
      3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; cyc = MC; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; cyc = MC; end
      3'd3: begin
        cyc = DC;
        if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      end
      3'd4: begin
        cyc = DC;
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_cyc, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          n;
    logic        early;
    old_hi = hi;
    old_lo = lo;
    n      = 0;
    early  = 1'b0;
    start  = 1'b1;
    md_op  = op;
    A      = a;
    B      = b;
    @(posedge clk); #1;
    start = 1'b0;
    md_op = 3'd0;
    while (busy && n < 40) begin
      if (hi !== old_hi || lo !== old_lo) early = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk({name, " busy cycles"}, 64'(n), 64'(exp_cyc));
    if (exp_cyc > 0) chk({name, " no early commit"}, 64'(early), 64'd0);
    chk({name, " hi"}, 64'(hi), 64'(exp_hi));
    chk({name, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int          cyc;
    int          n;
    logic        bad;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0]  = '{3'd5, 32'h11,        32'h0,        0,  32'h11,        32'h0};
    vecs[1]  = '{3'd6, 32'h22,        32'h0,        0,  32'h11,        32'h22};
    vecs[2]  = '{3'd4, 32'h5,         32'h0,        DC, 32'h11,        32'h22};
    vecs[3]  = '{3'd0, 32'hDEAD,      32'h1,        0,  32'h11,        32'h22};
    vecs[4]  = '{3'd7, 32'hBEEF,      32'h1,        0,  32'h11,        32'h22};
    vecs[5]  = '{3'd1, 32'hFFFFFFFE,  32'h3,        MC, 32'hFFFFFFFF,  32'hFFFFFFFA};
    vecs[6]  = '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, MC, 32'hFFFFFFFE,  32'h00000001};
    vecs[7]  = '{3'd3, 32'hFFFFFFF9,  32'h2,        DC, 32'hFFFFFFFF,  32'hFFFFFFFD};
    vecs[8]  = '{3'd3, 32'h80000000,  32'hFFFFFFFF, DC, 32'h0,         32'h80000000};
    vecs[9]  = '{3'd4, 32'hFFFFFFF9,  32'h2,        DC, 32'h1,         32'h7FFFFFFC};
    vecs[10] = '{3'd3, 32'h7,         32'hFFFFFFFE, DC, 32'h1,         32'hFFFFFFFD};
    vecs[11] = '{3'd3, 32'h5,         32'h0,        DC, 32'h1,         32'hFFFFFFFD};
    vecs[12] = '{3'd1, 32'h10000,     32'h10000,    MC, 32'h1,         32'h0};
    vecs[13] = '{3'd1, 32'h80000000,  32'h80000000, MC, 32'h40000000,  32'h0};

    reset = 1'b1; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    reset = 1'b0;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].cyc, vecs[i].hi, vecs[i].lo);
    m_hi = vecs[13].hi;
    m_lo = vecs[13].lo;

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      model_step(op, a, b, cyc);
      do_op($sformatf("rand%0d op%0d", i, op), op, a, b, cyc, m_hi, m_lo);
    end

    // Collision: mthi and div issued while a mult is in flight must be ignored.
    model_step(3'd1, 32'h12345678, 32'hFFFF0003, cyc);
    start = 1'b1; md_op = 3'd1; A = 32'h12345678; B = 32'hFFFF0003;
    @(posedge clk); #1;
    start = 1'b0;
    chk("collision busy after issue", 64'(busy), 64'd1);
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd5; A = 32'h55;
    @(posedge clk); #1;
    md_op = 3'd3; A = 32'h64; B = 32'h0;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    n = 3;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    chk("collision busy cycles", 64'(n), 64'(MC));
    chk("collision hi", 64'(hi), 64'(m_hi));
    chk("collision lo", 64'(lo), 64'(m_lo));

    // Reset in busy cycle 4 of a div aborts it; nothing may commit afterwards.
    start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (busy || hi != 32'd0 || lo != 32'd0) bad = 1'b1;
    end
    chk("abort no late commit", 64'(bad), 64'd0);

    reset = 1'b1; start = 1'b1; md_op = 3'd5; A = 32'hAA;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; md_op = 3'd0;
    chk("reset priority hi", 64'(hi), 64'd0);
    chk("reset priority busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
